countup_meter: RTL
==================

Name: countup_meter

Overview:
- Measures an interval instead of producing one: counts enabled clock cycles between a start pulse and a stop pulse, then presents the result over a valid/ready handshake.
- Used to measure how many cycles a countdown instance takes to assert done, and as a general interval probe in the LFSR/countdown test harness.
- Binary saturating up-counter with a three-state control FSM.

Parameters:
- MAX_COUNT, 16, largest countable value; the counter saturates here and flags overflow.
- WIDTH (localparam), $clog2(MAX_COUNT+1), width of the count result.

Ports:
- clock  input  1  single clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  pulse; begins a measurement (accepted in IDLE, or in HOLD together with a handshake).
- i_stop  input  1  pulse; ends a measurement (accepted in RUN only).
- i_enable  input  1  count qualifier; only cycles with i_enable=1 are counted.
- o_busy  output  1  high while in RUN.
- o_valid  output  1  result available.
- i_ready  input  1  consumer accepts the result.
- o_count  output  WIDTH  measured count; stable while o_valid=1.
- o_overflow  output  1  measurement saturated at MAX_COUNT; stable while o_valid=1.

Behaviour:
- One clock. Reset is synchronous and active-high on i_reset; the clock port is clock. i_reset overrides all other inputs in the same cycle.
- Reset values:
  - state=IDLE, internal counter=0, overflow flag=0.
  - o_busy=0, o_valid=0, o_count=0, o_overflow=0.
- IDLE:
  - i_start=1 -> RUN next cycle; counter<=0, overflow<=0.
  - i_stop ignored.
  - o_count and o_overflow keep their last presented values.
- RUN, evaluated per cycle:
  - i_stop=1 -> HOLD next cycle. o_count<=counter, o_overflow<=flag, o_valid<=1. The stop cycle's i_enable is not counted.
  - Otherwise, if i_enable=1:
    - counter<MAX_COUNT -> counter+1.
    - counter==MAX_COUNT -> counter holds, flag<=1.
  - i_start in RUN is ignored. With i_start and i_stop both high, stop wins.
- Count definition: enabled cycles strictly after the cycle start is sampled, up to but excluding the cycle stop is sampled. A stop in the cycle immediately after start gives 0.
- HOLD:
  - o_valid=1; o_count and o_overflow held constant.
  - i_ready=1 completes the transfer: o_valid<=0; next state IDLE, or RUN if i_start=1 in the same cycle (back-to-back measurement, counter cleared).
  - i_start without i_ready is ignored. i_stop ignored.
- Latency: o_valid rises the cycle after i_stop is sampled. o_busy falls in the same cycle.
- o_busy is a registered state decode (state==RUN).
- Reset mid-measurement or mid-handshake: result discarded, o_valid drops the next cycle, and all reset values are reapplied.
- Overflow flag is sticky within a measurement, cleared only on a new start or reset.
- Width: the counter never exceeds MAX_COUNT and never wraps.

Decomposition:
- Package countup_pkg:
  - state enum state_t {ST_IDLE, ST_RUN, ST_HOLD}.
  - Helper function for WIDTH from MAX_COUNT.
- Sub-module sat_counter #(MAX, WIDTH):
  - Inputs: clear, inc. Outputs: value, sat (sticky).
- The FSM and output registers live in countup_meter.

Test Plan:
- Reset then idle 10 cycles with i_stop toggling -> o_valid=0, o_busy=0, o_count=0 throughout.
- i_start at cycle 0, i_enable=1 constant, i_stop at cycle 5, i_ready=1 -> o_valid high at cycle 6 only, o_count=4, o_overflow=0.
- MAX_COUNT=16: start, i_enable=1 for 20 cycles, stop -> o_count=16, o_overflow=1. Counter observed at 16 without wrap.
- i_enable alternating 1/0 over 8 RUN cycles, i_ready held 0 for 5 cycles after o_valid rises -> o_count=4, held stable, o_valid held until i_ready, then cleared next cycle.
- Same cycle i_ready=1 and i_start=1 in HOLD -> RUN next cycle; the second measurement (3 enabled cycles) reports 3 independently of the first.
- i_reset asserted during RUN, and separately during HOLD with o_valid=1 -> next cycle o_valid=0, o_busy=0, o_count=0; a subsequent stop without start produces no result.

Source files
------------

// File: rtl/countup_pkg.sv
// rtl/countup_pkg.sv - shared state encoding and width helper for the interval meter
package countup_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - binary up-counter that stops at MAX and raises a sticky saturation flag
module sat_counter #(
    parameter int MAX   = 16,
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // An increment request at MAX is the overflow event: value holds, flag latches
    always_ff @(posedge clock) begin
        if (i_reset || clear) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (value == MAX_V) begin
                sat <= 1'b1;
            end else begin
                value <= value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countup_meter.sv
// rtl/countup_meter.sv - counts enabled cycles between start and stop, returns result via valid/ready
module countup_meter
    import countup_pkg::*;
#(
    parameter  int MAX_COUNT = 16,
    localparam int WIDTH     = count_width(MAX_COUNT)
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_enable,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    state_t           state;
    state_t           next_state;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             capture;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_sat;

    sat_counter #(
        .MAX   (MAX_COUNT),
        .WIDTH (WIDTH)
    ) u_counter (
        .clock   (clock),
        .i_reset (i_reset),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .value   (cnt_value),
        .sat     (cnt_sat)
    );

    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_RUN;
                    cnt_clear  = 1'b1;
                end
            end
            ST_RUN: begin
                // Stop wins over enable: the stop cycle itself is never counted
                if (i_stop) begin
                    next_state = ST_HOLD;
                    capture    = 1'b1;
                end else begin
                    cnt_inc = i_enable;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    next_state = i_start ? ST_RUN : ST_IDLE;
                    cnt_clear  = i_start;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so they align with the state register
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            state   <= next_state;
            o_busy  <= (next_state == ST_RUN);
            o_valid <= (next_state == ST_HOLD);
            if (capture) begin
                o_count    <= cnt_value;
                o_overflow <= cnt_sat;
            end
        end
    end

endmodule
